// File: rtl/mips_cpu_avalon_pkg.sv
// -----------------------------------------------------------------------------
// mips_cpu_avalon_pkg
// Shared types and helpers for the CPU-side Avalon-MM master and its lane
// aligner: access-size and FSM state enums, byteenable generation and the
// alignment/legality check applied to every CPU request.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_cpu_avalon_pkg;

   // CPU access size as presented on cpu_size; 2'b11 is reserved/illegal.
   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_RSVD = 2'b11
   } size_e;

   // Master FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUS  = 2'b01,
      RESP = 2'b10
   } state_e;

   // Byte lane enables for an access of the given size at byte offset off.
   function automatic logic [3:0] gen_byteenable(input size_e size, input logic [1:0] off);
      logic [3:0] be;
      case (size)
         SIZE_BYTE: be = 4'b0001 << off;
         SIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
         SIZE_WORD: be = 4'b1111;
         default:   be = 4'b0000;
      endcase
      return be;
   endfunction

   // True when the request must be rejected without a bus cycle:
   // misaligned half/word, or the reserved size code.
   function automatic logic access_fault(input size_e size, input logic [1:0] off);
      logic bad;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = off[0];
         SIZE_WORD: bad = (off != 2'b00);
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mips_cpu_avalon_master_if.sv
// -----------------------------------------------------------------------------
// mips_cpu_avalon_master_if
// Avalon-MM bus bundle between the CPU master and the memory fabric.
//   address     32  word-aligned byte address (master -> slave)
//   byteenable   4  lane enables, bit0 = bits 7:0 (master -> slave)
//   read         1  read strobe (master -> slave)
//   write        1  write strobe (master -> slave)
//   writedata   32  lane-replicated store data (master -> slave)
//   waitrequest  1  slave stall (slave -> master)
//   readdata    32  read data (slave -> master)
// -----------------------------------------------------------------------------
interface mips_cpu_avalon_master_if;
   logic [31:0] address;
   logic [3:0]  byteenable;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic        waitrequest;
   logic [31:0] readdata;

   modport master (
      output address, byteenable, read, write, writedata,
      input  waitrequest, readdata
   );

   modport slave (
      input  address, byteenable, read, write, writedata,
      output waitrequest, readdata
   );
endinterface

// File: rtl/mips_cpu_avalon_lane_align.sv
// -----------------------------------------------------------------------------
// mips_cpu_avalon_lane_align
// Purely combinational byte-lane steering shared by the load/store and fetch
// paths.
// Write path:
//   wr_size, wr_off, wr_data -> wr_be (byteenable), wr_lanes (replicated data)
// Read path:
//   rd_size, rd_off, rd_signed, rd_data -> rd_value (extracted, extended data)
// -----------------------------------------------------------------------------
module mips_cpu_avalon_lane_align
   import mips_cpu_avalon_pkg::*;
(
   input  size_e       wr_size,
   input  logic [1:0]  wr_off,
   input  logic [31:0] wr_data,
   output logic [3:0]  wr_be,
   output logic [31:0] wr_lanes,
   input  size_e       rd_size,
   input  logic [1:0]  rd_off,
   input  logic        rd_signed,
   input  logic [31:0] rd_data,
   output logic [31:0] rd_value
);

   logic [31:0] rd_shifted;

   // Store data is replicated across all lanes so the slave finds it on
   // whichever lane byteenable selects.
   always_comb begin
      wr_be = gen_byteenable(wr_size, wr_off);
      case (wr_size)
         SIZE_BYTE: wr_lanes = {4{wr_data[7:0]}};
         SIZE_HALF: wr_lanes = {2{wr_data[15:0]}};
         default:   wr_lanes = wr_data;
      endcase
   end

   // Bring the addressed lane down to bit 0, then sign- or zero-extend.
   always_comb begin
      rd_shifted = rd_data >> {rd_off, 3'b000};
      case (rd_size)
         SIZE_BYTE: rd_value = {{24{rd_signed & rd_shifted[7]}}, rd_shifted[7:0]};
         SIZE_HALF: rd_value = {{16{rd_signed & rd_shifted[15]}}, rd_shifted[15:0]};
         default:   rd_value = rd_shifted;
      endcase
   end

endmodule

// File: rtl/mips_cpu_avalon_master.sv
// -----------------------------------------------------------------------------
// mips_cpu_avalon_master
// Avalon-MM initiator for the CPU load/store/fetch unit. Takes one sized
// request at a time, issues a word-aligned read/write held stable through
// waitrequest, and returns extended load data with a one-cycle done pulse.
// Misaligned or illegal requests produce a one-cycle err pulse, no bus cycle.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cpu_req/we/addr/size/signed/wdata   CPU request (sampled in IDLE/RESP)
//   cpu_busy/done/err/rdata             CPU response (all registered)
//   av                  Avalon bus, master modport
//
// Optional build macro MIPS_AVALON_MASTER_TIMEOUT_EN: aborts a transfer with
// cpu_err after TIMEOUT_CYCLES waitrequest cycles. Without it a permanently
// stalled slave hangs the master and TIMEOUT_CYCLES is ignored.
// -----------------------------------------------------------------------------
module mips_cpu_avalon_master
   import mips_cpu_avalon_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [1:0]  cpu_size,
   input  logic        cpu_signed,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_busy,
   output logic        cpu_done,
   output logic        cpu_err,
   output logic [31:0] cpu_rdata,
   mips_cpu_avalon_master_if.master av
);

   state_e      state_q, state_d;
   logic        read_q, read_d;
   logic        write_q, write_d;
   logic [31:0] address_q, address_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   size_e       size_q, size_d;
   logic [1:0]  off_q, off_d;
   logic        signed_q, signed_d;

   logic        req_window;
   logic        req_bad;
   logic        req_take;
   logic        req_reject;
   logic        xfer_done;
   logic        tmo_hit;
   logic [3:0]  wr_be;
   logic [31:0] wr_lanes;
   logic [31:0] rd_value;

   // Write lanes come from the live CPU request; read extraction uses the
   // request fields latched at acceptance.
   mips_cpu_avalon_lane_align u_lane_align (
      .wr_size   (size_e'(cpu_size)),
      .wr_off    (cpu_addr[1:0]),
      .wr_data   (cpu_wdata),
      .wr_be     (wr_be),
      .wr_lanes  (wr_lanes),
      .rd_size   (size_q),
      .rd_off    (off_q),
      .rd_signed (signed_q),
      .rd_data   (av.readdata),
      .rd_value  (rd_value)
   );

   // RESP behaves like IDLE for acceptance so back-to-back requests lose no cycle.
   assign req_window = (state_q == IDLE) || (state_q == RESP);
   assign req_bad    = access_fault(size_e'(cpu_size), cpu_addr[1:0]);
   assign req_take   = cpu_req && req_window && !req_bad;
   assign req_reject = cpu_req && req_window && req_bad;
   assign xfer_done  = (state_q == BUS) && !av.waitrequest;

`ifdef MIPS_AVALON_MASTER_TIMEOUT_EN
   logic [31:0] tmo_q, tmo_d;

   // Abort on the edge where the stall count reaches TIMEOUT_CYCLES.
   assign tmo_hit = (state_q == BUS) && av.waitrequest &&
                    (tmo_q == (TIMEOUT_CYCLES - 32'd1));

   // Stall counter: cleared on acceptance, counts waitrequest cycles in BUS.
   always_comb begin
      if (req_take) begin
         tmo_d = 32'd0;
      end else if ((state_q == BUS) && av.waitrequest) begin
         tmo_d = tmo_q + 32'd1;
      end else begin
         tmo_d = tmo_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_q <= 32'd0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, RESP: begin
            if (req_take) begin
               state_d = BUS;
            end else begin
               state_d = IDLE;
            end
         end
         BUS: begin
            if (xfer_done) begin
               state_d = RESP;
            end else if (tmo_hit) begin
               state_d = IDLE;
            end else begin
               state_d = BUS;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output/datapath next values; bus fields hold unless a request is taken.
   always_comb begin
      read_d    = read_q;
      write_d   = write_q;
      address_d = address_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      rdata_d   = rdata_q;
      size_d    = size_q;
      off_d     = off_q;
      signed_d  = signed_q;
      if (req_take) begin
         address_d = {cpu_addr[31:2], 2'b00};
         be_d      = wr_be;
         wdata_d   = cpu_we ? wr_lanes : 32'h0000_0000;
         read_d    = ~cpu_we;
         write_d   = cpu_we;
         busy_d    = 1'b1;
         size_d    = size_e'(cpu_size);
         off_d     = cpu_addr[1:0];
         signed_d  = cpu_signed;
      end else if (req_reject) begin
         err_d = 1'b1;
      end else if (xfer_done) begin
         read_d  = 1'b0;
         write_d = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b1;
         // Stores leave the last load result visible.
         if (read_q) begin
            rdata_d = rd_value;
         end else begin
            rdata_d = rdata_q;
         end
      end else if (tmo_hit) begin
         read_d  = 1'b0;
         write_d = 1'b0;
         busy_d  = 1'b0;
         err_d   = 1'b1;
      end else begin
         busy_d = busy_q;
      end
   end

   // State and output registers; reset overrides any transfer in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         address_q <= 32'h0000_0000;
         be_q      <= 4'b0000;
         wdata_q   <= 32'h0000_0000;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= 32'h0000_0000;
         size_q    <= SIZE_BYTE;
         off_q     <= 2'b00;
         signed_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         read_q    <= read_d;
         write_q   <= write_d;
         address_q <= address_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         size_q    <= size_d;
         off_q     <= off_d;
         signed_q  <= signed_d;
      end
   end

   assign cpu_busy      = busy_q;
   assign cpu_done      = done_q;
   assign cpu_err       = err_q;
   assign cpu_rdata     = rdata_q;
   assign av.address    = address_q;
   assign av.byteenable = be_q;
   assign av.read       = read_q;
   assign av.write      = write_q;
   assign av.writedata  = wdata_q;

endmodule

// File: tb/tb_mips_cpu_avalon_master.sv
// -----------------------------------------------------------------------------
// tb_mips_cpu_avalon_master
// Randomized scoreboard bench. The stimulus process computes expected bus
// cycles and responses from a byte-level reference model and queues them; a
// separate monitor compares whatever the DUT presents against those queues.
// -----------------------------------------------------------------------------
module tb_mips_cpu_avalon_master;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wd;
   } bus_exp_t;

   typedef struct {
      bit          is_err;
      int          cyc;
      logic [31:0] rdata;
   } resp_exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [1:0]  cpu_size;
   logic        cpu_signed;
   logic [31:0] cpu_wdata;
   logic        cpu_busy;
   logic        cpu_done;
   logic        cpu_err;
   logic [31:0] cpu_rdata;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   bus_exp_t    bus_q[$];
   resp_exp_t   resp_q[$];
   logic [31:0] last_rdata;

   mips_cpu_avalon_master_if av ();

   mips_cpu_avalon_master dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_size   (cpu_size),
      .cpu_signed (cpu_signed),
      .cpu_wdata  (cpu_wdata),
      .cpu_busy   (cpu_busy),
      .cpu_done   (cpu_done),
      .cpu_err    (cpu_err),
      .cpu_rdata  (cpu_rdata),
      .av         (av)
   );

   always #5 clk = ~clk;

   // Cycle index: value k means "the period following rising edge k".
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model (byte-level arithmetic) ----------------
   function automatic int nbytes(input logic [1:0] size);
      if (size == 2'd0) return 1;
      if (size == 2'd1) return 2;
      return 4;
   endfunction

   function automatic bit is_bad(input logic [1:0] size, input logic [31:0] addr);
      return (size == 2'd3) || ((int'(addr[1:0]) % nbytes(size)) != 0);
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
      logic [3:0] be = 4'b0000;
      for (int k = 0; k < nbytes(size); k++) be[(int'(addr[1:0]) + k) % 4] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] m_wd(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] wd = 32'h0;
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdata[8*(i % nbytes(size)) +: 8];
      return wd;
   endfunction

   function automatic logic [31:0] m_rd(input logic [1:0] size, input logic [31:0] addr,
                                        input logic sgn, input logic [31:0] rd);
      logic [31:0] v = 32'h0;
      int n = nbytes(size);
      int off = int'(addr[1:0]);
      for (int k = 0; k < n; k++) v[8*k +: 8] = rd[8*(off + k) +: 8];
      if (sgn && n < 4 && v[8*n - 1]) begin
         for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
      end
      return v;
   endfunction

   // ---------------- monitor ----------------
   bit          in_xfer = 1'b0;
   logic [31:0] s_addr, s_wd;
   logic [3:0]  s_be;
   logic        s_we;
   bus_exp_t    mb;
   resp_exp_t   mr;

   always begin
      @(negedge clk);
      #3;
      if (reset) begin
         in_xfer = 1'b0;
      end else begin
         if (av.read || av.write) begin
            chk("rw_exclusive", 32'(av.read & av.write), 32'h0);
            chk("busy_during_bus", 32'(cpu_busy), 32'h1);
            if (in_xfer) begin
               chk("stall_addr_stable", av.address, s_addr);
               chk("stall_be_stable", 32'(av.byteenable), 32'(s_be));
               chk("stall_wd_stable", av.writedata, s_wd);
               chk("stall_we_stable", 32'(av.write), 32'(s_we));
            end else begin
               s_addr  = av.address;
               s_be    = av.byteenable;
               s_wd    = av.writedata;
               s_we    = av.write;
               in_xfer = 1'b1;
            end
            if (!av.waitrequest) begin
               in_xfer = 1'b0;
               if (bus_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_bus_cycle actual addr=0x%08h read=%0b write=%0b required no bus cycle",
                           av.address, av.read, av.write);
               end else begin
                  mb = bus_q.pop_front();
                  chk("bus_address", av.address, mb.addr);
                  chk("bus_byteenable", 32'(av.byteenable), 32'(mb.be));
                  chk("bus_write", 32'(av.write), 32'(mb.we));
                  chk("bus_read", 32'(av.read), 32'(!mb.we));
                  if (mb.we) chk("bus_writedata", av.writedata, mb.wd);
               end
            end
         end
         if (cpu_done || cpu_err) begin
            if (resp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_resp actual done=%0b err=%0b required no response",
                        cpu_done, cpu_err);
            end else begin
               mr = resp_q.pop_front();
               chk("resp_kind_err_done", 32'({cpu_err, cpu_done}), mr.is_err ? 32'h2 : 32'h1);
               chk("resp_cycle", 32'(cyc), 32'(mr.cyc));
               chk("cpu_rdata", cpu_rdata, mr.rdata);
               chk("busy_at_resp", 32'(cpu_busy), 32'h0);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Issue one request and drive the slave; returns in the response cycle,
   // where the next request may already be presented.
   task automatic do_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic sgn, input logic [31:0] wdata, input logic [31:0] rd,
                         input int w);
      int        t;
      bit        bad;
      bus_exp_t  b;
      resp_exp_t r;
      t   = cyc + 1;
      bad = is_bad(size, addr);
      if (bad) begin
         r.is_err = 1'b1;
         r.cyc    = t;
         r.rdata  = last_rdata;
      end else begin
         b.addr = {addr[31:2], 2'b00};
         b.be   = m_be(size, addr);
         b.we   = we;
         b.wd   = m_wd(size, wdata);
         bus_q.push_back(b);
         if (!we) last_rdata = m_rd(size, addr, sgn, rd);
         r.is_err = 1'b0;
         r.cyc    = t + 1 + w;
         r.rdata  = last_rdata;
      end
      resp_q.push_back(r);
      cpu_req        = 1'b1;
      cpu_we         = we;
      cpu_addr       = addr;
      cpu_size       = size;
      cpu_signed     = sgn;
      cpu_wdata      = wdata;
      av.waitrequest = (!bad && w > 0);
      av.readdata    = (w > 0) ? $urandom : rd;
      step();
      cpu_req = 1'b0;
      if (!bad) begin
         for (int i = 0; i < w; i++) step();
         av.waitrequest = 1'b0;
         av.readdata    = rd;
         step();
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_read"}, 32'(av.read), 32'h0);
      chk({tag, "_write"}, 32'(av.write), 32'h0);
      chk({tag, "_address"}, av.address, 32'h0);
      chk({tag, "_byteenable"}, 32'(av.byteenable), 32'h0);
      chk({tag, "_writedata"}, av.writedata, 32'h0);
      chk({tag, "_busy"}, 32'(cpu_busy), 32'h0);
      chk({tag, "_done"}, 32'(cpu_done), 32'h0);
      chk({tag, "_err"}, 32'(cpu_err), 32'h0);
      chk({tag, "_rdata"}, cpu_rdata, 32'h0);
   endtask

   initial begin
      logic [1:0]  sz;
      logic [31:0] ad;
      int          r;
      reset          = 1'b1;
      cpu_req        = 1'b0;
      cpu_we         = 1'b0;
      cpu_addr       = 32'h0;
      cpu_size       = 2'd0;
      cpu_signed     = 1'b0;
      cpu_wdata      = 32'h0;
      av.waitrequest = 1'b0;
      av.readdata    = 32'h0;
      last_rdata     = 32'h0;
      repeat (3) step();
      chk_all_zero("reset");
      reset = 1'b0;
      step();

      // Directed cases with literal expectations.
      do_txn(1'b0, 2'd2, 32'hBFC0_0004, 1'b0, 32'h0, 32'h1234_5678, 0);
      chk("dir_word_rdata", cpu_rdata, 32'h1234_5678);
      step();
      do_txn(1'b0, 2'd0, 32'hBFC0_0003, 1'b1, 32'h0, 32'h80FF_FFFF, 0);
      chk("dir_sbyte_rdata", cpu_rdata, 32'hFFFF_FF80);
      do_txn(1'b0, 2'd0, 32'hBFC0_0003, 1'b0, 32'h0, 32'h80FF_FFFF, 1);
      chk("dir_ubyte_rdata", cpu_rdata, 32'h0000_0080);
      do_txn(1'b1, 2'd1, 32'h0000_0102, 1'b0, 32'h0000_BEEF, 32'h0, 3);
      chk("dir_store_keeps_rdata", cpu_rdata, 32'h0000_0080);
      step();
      do_txn(1'b0, 2'd2, 32'h0000_0001, 1'b0, 32'h0, 32'h0, 0);
      repeat (2) step();
      do_txn(1'b0, 2'd3, 32'h0000_0010, 1'b0, 32'h0, 32'h0, 0);

      // Randomized traffic, including back-to-back and illegal requests.
      for (int n = 0; n < 300; n++) begin
         r  = $urandom_range(0, 9);
         sz = (r == 9) ? 2'd3 : 2'(r % 3);
         ad = $urandom;
         if ($urandom_range(0, 3) != 0) ad = ad & ~32'(nbytes(sz) - 1);
         do_txn(1'($urandom_range(0, 1)), sz, ad, 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom_range(0, 3));
         repeat ($urandom_range(0, 2)) step();
      end

      // Reset in the middle of a long stall.
      step();
      cpu_req        = 1'b1;
      cpu_we         = 1'b0;
      cpu_size       = 2'd2;
      cpu_addr       = 32'h0000_0040;
      av.waitrequest = 1'b1;
      step();
      cpu_req = 1'b0;
      chk("stall_read_high", 32'(av.read), 32'h1);
      repeat (2) step();
      reset = 1'b1;
      step();
      chk_all_zero("midreset");
      reset          = 1'b0;
      av.waitrequest = 1'b0;
      last_rdata     = 32'h0;
      repeat (4) step();
      do_txn(1'b0, 2'd1, 32'h0000_0042, 1'b1, 32'h0, 32'h9ABC_1234, 1);
      chk("post_reset_rdata", cpu_rdata, 32'hFFFF_9ABC);

      repeat (4) step();
      chk("bus_queue_drained", 32'(bus_q.size()), 32'h0);
      chk("resp_queue_drained", 32'(resp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips_cpu_avalon_master.md
Name: mips_cpu_avalon_master

Overview:
- Avalon-MM initiator (master) between the CPU core's load/store/fetch unit and the Avalon memory bus.
- Accepts one CPU-side request at a time, sized byte, half or word.
- Converts it to a word-aligned Avalon read or write with byteenable and lane-replicated writedata, holding it stable through waitrequest.
- Returns lane-extracted, sign- or zero-extended read data with a one-cycle done pulse.

Parameters:
- TIMEOUT_CYCLES, 1024: waitrequest cycles before abort. Used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  request strobe; sampled only in IDLE
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address
- cpu_size  in  2  00 byte, 01 half, 10 word; 11 is illegal
- cpu_signed  in  1  sign-extend load result
- cpu_wdata  in  32  store data, right-justified
- cpu_busy  out  1  high from acceptance until done or err
- cpu_done  out  1  one-cycle completion pulse
- cpu_err  out  1  one-cycle pulse: misaligned, illegal size, or timeout
- cpu_rdata  out  32  extended load data; valid while cpu_done is high, held afterwards
- address  out  32  Avalon word address, {cpu_addr[31:2],2'b00}
- byteenable  out  4  lane enables; bit0 = bits 7:0 = lowest byte address
- read  out  1  Avalon read
- write  out  1  Avalon write
- writedata  out  32  lane-replicated store data
- waitrequest  in  1  slave stall
- readdata  in  32  slave read data

Behaviour:
- Reset values: read=0, write=0, address=0, byteenable=0, writedata=0, cpu_busy=0, cpu_done=0, cpu_err=0, cpu_rdata=0; state=IDLE.
- Reset wins over everything. Reset mid-transfer drops read/write at that edge, returns to IDLE, and issues no done or err.
- States are IDLE, BUS, RESP. All outputs are registered.
- IDLE: on an edge with cpu_req=1, check alignment first.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal: cpu_size=11.
  - If misaligned or illegal: no bus cycle; next cycle cpu_err=1, cpu_busy=0; stay in IDLE.
  - Otherwise latch the request, drive read or write, set cpu_busy=1, and go to BUS.
- Byteenable:
  - byte: 4'b0001 << addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- Writedata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- BUS: address, byteenable, read/write and writedata are held constant while waitrequest=1.
  - The transfer completes on the first edge where waitrequest=0. At that edge deassert read/write and go to RESP.
  - On a read, capture readdata >> (8*addr[1:0]) at that same edge and extend:
    - byte: bits 7:0, sign-extended if cpu_signed, else zero-extended
    - half: bits 15:0, extended the same way
    - word: all 32 bits
- RESP: cpu_done=1 for exactly one cycle, cpu_busy=0 in the same cycle, then IDLE. A new cpu_req may be accepted on that edge.
- Latency with zero wait states: request at edge t, read/write high in cycle t+1, done high in cycle t+2. Each waitrequest cycle adds one cycle.
- cpu_req while busy is ignored; no queueing.
- read and write are never both high.
- Store responses leave cpu_rdata unchanged.

Optional Feature:
- Macro: MIPS_AVALON_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUS and increments each cycle waitrequest=1.
  - When it reaches TIMEOUT_CYCLES, drop read/write and pulse cpu_err (not cpu_done) in the next cycle. cpu_busy clears in that same cycle and the state returns to IDLE.
- Undefined: no counter; a permanently stalled slave hangs the master. The TIMEOUT_CYCLES parameter is ignored.

Decomposition:
- Shared package mips_cpu_avalon_pkg:
  - size enum: SIZE_BYTE, SIZE_HALF, SIZE_WORD
  - state enum: IDLE, BUS, RESP
  - function for byteenable generation
- One sub-module, mips_cpu_avalon_lane_align: combinational.
  - Write path: lane replication and byteenable.
  - Read path: extraction and extension.
  - Reused by the fetch path.

Test Plan:
- Word read at 0xBFC00004, slave data 0x12345678, waitrequest=0 → address=0xBFC00004, byteenable=1111, done in cycle t+2, cpu_rdata=0x12345678.
- Signed byte load at 0xBFC00003, readdata 0x80FFFFFF → byteenable=1000, cpu_rdata=0xFFFFFF80; the same load unsigned gives 0x00000080.
- Half store of 0xBEEF at 0x00000102 → byteenable=1100, writedata=0xBEEFBEEF; with waitrequest held 3 cycles, outputs stay stable and done comes 3 cycles later.
- Misaligned word load at 0x00000001 → no read asserted, cpu_err pulse one cycle later, cpu_done never rises.
- Reset asserted during a 5-cycle waitrequest stall → read=0 after that edge, no done or err pulse, next request accepted normally.
- With MIPS_AVALON_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8, waitrequest stuck at 1 → read drops after 8 stall cycles, cpu_err pulses, cpu_busy=0.
